// File: rtl/display_scan_ctrl.sv
// Scan controller and source arbiter for a 4-digit seven-segment display.
// Snapshots one time source per frame and steps the digit/anode select with a blank gap per slot.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  src_Req,
  input  logic [15:0] clk_Digits,
  input  logic        clk_Pm,
  input  logic [15:0] alm_Digits,
  input  logic        alm_Pm,
  input  logic [15:0] puz_Digits,
  input  logic [3:0]  blink_Mask,
  input  logic        disp_En,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [1:0]  digit_sel,
  output logic [1:0]  anode_sel,
  output logic        display_On,
  output logic        am_Or_Pm,
  output logic [1:0]  active_Src,
  output logic        frame_Tick
);

  localparam int ON_CYC = REFRESH_DIV - BLANK_CYC;
  localparam int CW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW     = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {ST_GAP, ST_ON} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      scan_reg;
  logic [15:0]     digits_reg;
  logic            pm_reg;
  logic [1:0]      src_reg;
  logic [3:0]      mask_reg;
  logic [BW-1:0]   blink_cnt_reg;
  logic            blink_hidden_reg;
  logic            disp_on_reg;
  logic            tick_reg;

  logic [1:0]      src_next;
  logic [15:0]     digits_next;
  logic            pm_next;
  logic            blank;
  logic            lit;
  logic            gap_done;
  logic            on_done;

  // Fixed priority: puzzle over alarm over clock; no request falls back to clock.
  always_comb begin
    src_next    = 2'd0;
    digits_next = clk_Digits;
    pm_next     = clk_Pm;
    if (src_Req[2]) begin
      src_next    = 2'd2;
      digits_next = puz_Digits;
      pm_next     = 1'b0;
    end else if (src_Req[1]) begin
      src_next    = 2'd1;
      digits_next = alm_Digits;
      pm_next     = alm_Pm;
    end
  end

  // Leading-zero suppression applies to time sources only, never to puzzle digits.
  assign blank = (blink_hidden_reg && mask_reg[scan_reg]) ||
                 ((scan_reg == 2'd3) && (digits_reg[15:12] == 4'd0) && (src_reg != 2'd2));
  assign lit      = disp_En && !blank;
  assign gap_done = (cnt_reg == CW'(BLANK_CYC - 1));
  assign on_done  = (cnt_reg == CW'(ON_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_GAP;
      cnt_reg          <= '0;
      scan_reg         <= 2'd0;
      digits_reg       <= 16'd0;
      pm_reg           <= 1'b0;
      src_reg          <= 2'd0;
      mask_reg         <= 4'd0;
      blink_cnt_reg    <= '0;
      blink_hidden_reg <= 1'b0;
      disp_on_reg      <= 1'b0;
      tick_reg         <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      case (state_reg)
        ST_GAP: begin
          if (gap_done) begin
            state_reg   <= ST_ON;
            cnt_reg     <= '0;
            disp_on_reg <= lit;
          end else begin
            cnt_reg     <= cnt_reg + 1'b1;
            disp_on_reg <= 1'b0;
          end
        end
        ST_ON: begin
          if (on_done) begin
            state_reg   <= ST_GAP;
            cnt_reg     <= '0;
            scan_reg    <= scan_reg + 2'd1;
            disp_on_reg <= 1'b0;
            // Frame boundary: everything shown next frame is captured on this edge.
            if (scan_reg == 2'd3) begin
              tick_reg   <= 1'b1;
              src_reg    <= src_next;
              digits_reg <= digits_next;
              pm_reg     <= pm_next;
              mask_reg   <= blink_Mask;
              if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_reg    <= '0;
                blink_hidden_reg <= !blink_hidden_reg;
              end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
              end
            end
          end else begin
            cnt_reg     <= cnt_reg + 1'b1;
            disp_on_reg <= lit;
          end
        end
        default: begin
          state_reg   <= ST_GAP;
          cnt_reg     <= '0;
          disp_on_reg <= 1'b0;
        end
      endcase
    end
  end

  assign digit3     = digits_reg[15:12];
  assign digit2     = digits_reg[11:8];
  assign digit1     = digits_reg[7:4];
  assign digit0     = digits_reg[3:0];
  assign digit_sel  = scan_reg;
  assign anode_sel  = scan_reg;
  assign display_On = disp_on_reg;
  assign am_Or_Pm   = pm_reg;
  assign active_Src = src_reg;
  assign frame_Tick = tick_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: slot timing, arbitration, snapshotting,
// blinking, display enable and asynchronous reset.
module tb_display_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  src_Req;
  logic [15:0] clk_Digits, alm_Digits, puz_Digits;
  logic        clk_Pm, alm_Pm, disp_En;
  logic [3:0]  blink_Mask;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic [1:0]  digit_sel, anode_sel, active_Src;
  logic        display_On, am_Or_Pm, frame_Tick;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int f;
  logic [1:0]  e_sel, e_src;
  logic [15:0] e_dig;
  logic        e_on, e_pm, e_tick, hidden;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .src_Req(src_Req),
    .clk_Digits(clk_Digits), .clk_Pm(clk_Pm),
    .alm_Digits(alm_Digits), .alm_Pm(alm_Pm), .puz_Digits(puz_Digits),
    .blink_Mask(blink_Mask), .disp_En(disp_En),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .digit_sel(digit_sel), .anode_sel(anode_sel), .display_On(display_On),
    .am_Or_Pm(am_Or_Pm), .active_Src(active_Src), .frame_Tick(frame_Tick)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_Tick)
      $display("[TB] frame tick at cyc %0d: src=%0d digits=%h pm=%0d", cyc, active_Src,
               {digit3, digit2, digit1, digit0}, am_Or_Pm);
  endtask

  // Reset release, plain scanning with the clock source, first frame shows reset values.
  task automatic test_reset;
    reset_n = 1'b0; src_Req = 3'b001; clk_Digits = 16'h1234; clk_Pm = 1'b1;
    alm_Digits = 16'h0630; alm_Pm = 1'b1; puz_Digits = 16'h0000;
    blink_Mask = 4'b0000; disp_En = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; cyc = 0;
    #1;
    tests++; if ({digit_sel, anode_sel} !== 4'b0000) begin fails++; $display("FAIL reset_sel got=%b exp=0000", {digit_sel, anode_sel}); end
    tests++; if ({display_On, frame_Tick} !== 2'b00) begin fails++; $display("FAIL reset_on_tick got=%b exp=00", {display_On, frame_Tick}); end
    tests++; if ({digit3, digit2, digit1, digit0, am_Or_Pm, active_Src} !== 19'd0) begin fails++; $display("FAIL reset_snap got=%h exp=0", {digit3, digit2, digit1, digit0, am_Or_Pm, active_Src}); end
    while (cyc < 95) begin
      tick();
      f = cyc / 32; e_sel = 2'((cyc / RD) % 4); e_tick = (cyc % 32) == 0;
      e_dig = (f == 0) ? 16'h0000 : 16'h1234; e_pm = (f != 0); e_src = 2'd0;
      e_on = ((cyc % RD) >= BC) && !(e_sel == 2'd3 && f == 0);
      tests++; if ({digit_sel, anode_sel} !== {e_sel, e_sel}) begin fails++; $display("FAIL scan_sel cyc=%0d got=%b exp=%b", cyc, {digit_sel, anode_sel}, {e_sel, e_sel}); end
      tests++; if (display_On !== e_on) begin fails++; $display("FAIL scan_on cyc=%0d got=%b exp=%b", cyc, display_On, e_on); end
      tests++; if (frame_Tick !== e_tick) begin fails++; $display("FAIL scan_tick cyc=%0d got=%b exp=%b", cyc, frame_Tick, e_tick); end
      tests++; if ({digit3, digit2, digit1, digit0, am_Or_Pm, active_Src} !== {e_dig, e_pm, e_src}) begin fails++; $display("FAIL scan_snap cyc=%0d got=%h exp=%h", cyc, {digit3, digit2, digit1, digit0, am_Or_Pm, active_Src}, {e_dig, e_pm, e_src}); end
    end
  endtask

  // Switch to alarm mid-frame; clock digits hold until the boundary, then slot 3 is suppressed.
  task automatic test_alarm_switch;
    while (cyc < 159) begin
      tick();
      f = cyc / 32; e_sel = 2'((cyc / RD) % 4); e_tick = (cyc % 32) == 0;
      if (f == 3) begin e_dig = 16'h1234; e_pm = 1'b1; e_src = 2'd0; end
      else        begin e_dig = 16'h0630; e_pm = 1'b1; e_src = 2'd1; end
      e_on = ((cyc % RD) >= BC) && !(e_sel == 2'd3 && f == 4);
      tests++; if (digit_sel !== e_sel) begin fails++; $display("FAIL alarm_sel cyc=%0d got=%0d exp=%0d", cyc, digit_sel, e_sel); end
      tests++; if (display_On !== e_on) begin fails++; $display("FAIL alarm_on cyc=%0d got=%b exp=%b", cyc, display_On, e_on); end
      tests++; if (frame_Tick !== e_tick) begin fails++; $display("FAIL alarm_tick cyc=%0d got=%b exp=%b", cyc, frame_Tick, e_tick); end
      tests++; if ({digit3, digit2, digit1, digit0, am_Or_Pm, active_Src} !== {e_dig, e_pm, e_src}) begin fails++; $display("FAIL alarm_snap cyc=%0d got=%h exp=%h", cyc, {digit3, digit2, digit1, digit0, am_Or_Pm, active_Src}, {e_dig, e_pm, e_src}); end
      if (cyc == 108) begin src_Req = 3'b010; clk_Digits = 16'h5678; end
    end
  endtask

  // All requests: puzzle wins, leading zero is shown, no PM indicator.
  task automatic test_puzzle_priority;
    while (cyc < 223) begin
      tick();
      f = cyc / 32; e_sel = 2'((cyc / RD) % 4);
      if (f == 5) begin e_dig = 16'h0630; e_pm = 1'b1; e_src = 2'd1; end
      else        begin e_dig = 16'h0123; e_pm = 1'b0; e_src = 2'd2; end
      e_on = ((cyc % RD) >= BC) && !(e_sel == 2'd3 && f == 5);
      tests++; if (display_On !== e_on) begin fails++; $display("FAIL puzzle_on cyc=%0d got=%b exp=%b", cyc, display_On, e_on); end
      tests++; if ({digit3, digit2, digit1, digit0, am_Or_Pm, active_Src} !== {e_dig, e_pm, e_src}) begin fails++; $display("FAIL puzzle_snap cyc=%0d got=%h exp=%h", cyc, {digit3, digit2, digit1, digit0, am_Or_Pm, active_Src}, {e_dig, e_pm, e_src}); end
      if (cyc == 170) begin src_Req = 3'b111; puz_Digits = 16'h0123; alm_Digits = 16'h1111; end
    end
  endtask

  // Blink on slots 0 and 1: two frames visible, two hidden, counting frames from reset.
  task automatic test_blink;
    while (cyc < 383) begin
      tick();
      f = cyc / 32; e_sel = 2'((cyc / RD) % 4);
      hidden = ((f / BF) % 2) == 1;
      if (f == 7) begin e_dig = 16'h0123; e_pm = 1'b0; e_src = 2'd2; e_on = (cyc % RD) >= BC; end
      else begin
        e_dig = 16'h5678; e_pm = 1'b1; e_src = 2'd0;
        e_on = ((cyc % RD) >= BC) && !(hidden && e_sel < 2'd2);
      end
      tests++; if (display_On !== e_on) begin fails++; $display("FAIL blink_on cyc=%0d got=%b exp=%b", cyc, display_On, e_on); end
      tests++; if ({digit3, digit2, digit1, digit0, am_Or_Pm, active_Src} !== {e_dig, e_pm, e_src}) begin fails++; $display("FAIL blink_snap cyc=%0d got=%h exp=%h", cyc, {digit3, digit2, digit1, digit0, am_Or_Pm, active_Src}, {e_dig, e_pm, e_src}); end
      if (cyc == 230) begin src_Req = 3'b001; blink_Mask = 4'b0011; end
    end
  endtask

  // Display disabled for frame 12: dark, but scanning and ticks continue.
  task automatic test_disable;
    disp_En = 1'b0;
    while (cyc < 447) begin
      tick();
      f = cyc / 32; e_sel = 2'((cyc / RD) % 4); e_tick = (cyc % 32) == 0;
      e_on = (f == 13) && ((cyc % RD) >= BC);
      tests++; if (digit_sel !== e_sel) begin fails++; $display("FAIL disable_sel cyc=%0d got=%0d exp=%0d", cyc, digit_sel, e_sel); end
      tests++; if (display_On !== e_on) begin fails++; $display("FAIL disable_on cyc=%0d got=%b exp=%b", cyc, display_On, e_on); end
      tests++; if (frame_Tick !== e_tick) begin fails++; $display("FAIL disable_tick cyc=%0d got=%b exp=%b", cyc, frame_Tick, e_tick); end
      if (cyc == 415) disp_En = 1'b1;
    end
  endtask

  // Asynchronous reset mid-ON in slot 2, then full restart of slot timing.
  task automatic test_async_reset;
    while (cyc < 468) tick();
    tests++; if ({digit_sel, display_On} !== 3'b101) begin fails++; $display("FAIL areset_pre got=%b exp=101", {digit_sel, display_On}); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if ({digit_sel, anode_sel, display_On, frame_Tick, am_Or_Pm, active_Src} !== 8'd0) begin fails++; $display("FAIL areset_now got=%b exp=0", {digit_sel, anode_sel, display_On, frame_Tick, am_Or_Pm, active_Src}); end
    tests++; if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin fails++; $display("FAIL areset_digits got=%h exp=0000", {digit3, digit2, digit1, digit0}); end
    @(posedge clk); #1;
    tests++; if ({digit_sel, display_On, active_Src} !== 5'd0) begin fails++; $display("FAIL areset_hold got=%b exp=0", {digit_sel, display_On, active_Src}); end
    @(negedge clk);
    reset_n = 1'b1; cyc = 0;
    while (cyc < 40) begin
      tick();
      f = cyc / 32; e_sel = 2'((cyc / RD) % 4); e_tick = (cyc % 32) == 0;
      if (f == 0) begin e_dig = 16'h0000; e_pm = 1'b0; end
      else        begin e_dig = 16'h5678; e_pm = 1'b1; end
      e_on = ((cyc % RD) >= BC) && !(e_sel == 2'd3 && f == 0);
      tests++; if (digit_sel !== e_sel) begin fails++; $display("FAIL restart_sel cyc=%0d got=%0d exp=%0d", cyc, digit_sel, e_sel); end
      tests++; if (display_On !== e_on) begin fails++; $display("FAIL restart_on cyc=%0d got=%b exp=%b", cyc, display_On, e_on); end
      tests++; if (frame_Tick !== e_tick) begin fails++; $display("FAIL restart_tick cyc=%0d got=%b exp=%b", cyc, frame_Tick, e_tick); end
      tests++; if ({digit3, digit2, digit1, digit0, am_Or_Pm, active_Src} !== {e_dig, e_pm, 2'd0}) begin fails++; $display("FAIL restart_snap cyc=%0d got=%h exp=%h", cyc, {digit3, digit2, digit1, digit0, am_Or_Pm, active_Src}, {e_dig, e_pm, 2'd0}); end
    end
  endtask

  initial begin
    test_reset();
    test_alarm_switch();
    test_puzzle_priority();
    test_blink();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
